// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one buffer write port among four producers with bounded bursts.
// Optional per-producer ack counters on the stats port are enabled by defining FIFO_ARB_STATS_EN.
module fifo_write_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   req_data,
    input  logic                  buffer_full,
    output logic [3:0]            ack,
    output logic [3:0]            grant,
    output logic                  busy,
    output logic                  data_1_en,
    output logic [DATA_W-1:0]     data_1
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [63:0]           stats
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(MAX_BURST - 1);

    state_t      r_state;
    logic [1:0]  r_owner;
    logic [3:0]  r_burst_cnt;
    logic [1:0]  r_rr_ptr;
    logic [3:0]  r_grant;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [1:0]  w_owner_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [1:0]  w_rr_nxt;
    logic [1:0]  w_pick;
    logic        w_req_own;
    logic        w_accept;
    logic [DATA_W-1:0] w_data_sel;

    assign w_req_own  = req[r_owner];
    assign w_accept   = (r_state == BURST) && w_req_own && !buffer_full;
    assign w_data_sel = req_data[r_owner*DATA_W +: DATA_W];

    assign ack       = w_accept ? (4'b0001 << r_owner) : 4'b0000;
    assign data_1_en = w_accept;
    assign data_1    = w_accept ? w_data_sel : '0;
    assign grant     = r_grant;
    assign busy      = r_busy;

    // Descending scan so the requester closest to rr_ptr wins.
    always_comb begin
        logic [1:0] idx;
        w_pick = r_rr_ptr;
        idx    = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = r_rr_ptr + 2'(k);
            if (req[idx]) begin
                w_pick = idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_burst_cnt;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = BURST;
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = 4'd0;
                end
            end
            BURST: begin
                if (!w_req_own) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = r_owner + 2'd1;
                end else if (w_accept) begin
                    w_cnt_nxt = r_burst_cnt + 4'd1;
                    if (r_burst_cnt == LP_LAST) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = r_owner + 2'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= 2'd0;
            r_burst_cnt <= 4'd0;
            r_rr_ptr    <= 2'd0;
            r_grant     <= 4'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant     <= (w_state_nxt == BURST) ? (4'b0001 << w_owner_nxt) : 4'b0000;
            r_busy      <= (w_state_nxt == BURST);
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [3:0][15:0] r_stats;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stats <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    r_stats[i] <= r_stats[i] + 16'd1;
                end
            end
        end
    end

    assign stats = r_stats;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, single burst, burst limit, fairness, stall, async reset.
module tb_fifo_write_arbiter;

    localparam int DATA_W = 16;

    logic               clock;
    logic               reset;
    logic [3:0]         req;
    logic [4*DATA_W-1:0] req_data;
    logic               buffer_full;
    logic [3:0]         ack;
    logic [3:0]         grant;
    logic               busy;
    logic               data_1_en;
    logic [DATA_W-1:0]  data_1;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0]        stats;
`endif

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .buffer_full (buffer_full),
        .ack         (ack),
        .grant       (grant),
        .busy        (busy),
        .data_1_en   (data_1_en),
        .data_1      (data_1)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats       (stats)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'h0; req_data = '0; buffer_full = 1'b0;
        #2;
        checks++; if (grant !== 4'h0) begin errors++; $display("FAIL reset_grant got %h exp 0", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        req = 4'hF;
        tick();
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack got %h exp 0", ack); end
        checks++; if (data_1_en !== 1'b0 || data_1 !== 16'h0) begin errors++; $display("FAIL reset_write got en=%b d=%h exp 0/0", data_1_en, data_1); end
        checks++; if (grant !== 4'h0) begin errors++; $display("FAIL reset_held_grant got %h exp 0", grant); end
        req = 4'h0;
        reset = 1'b1;
        tick();
        checks++; if (grant !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release got g=%h b=%b exp 0/0", grant, busy); end
    endtask

    task automatic test_single();
        logic [15:0] w;
        req = 4'b0100; req_data[2*16 +: 16] = 16'hA001;
        #1;
        checks++; if (ack !== 4'h0 || data_1_en !== 1'b0) begin errors++; $display("FAIL single_idle got ack=%h en=%b exp 0/0", ack, data_1_en); end
        tick();
        checks++; if (grant !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL single_grant got g=%h b=%b exp 4/1", grant, busy); end
        for (int i = 0; i < 3; i++) begin
            w = 16'hA001 + 16'(i);
            req_data[2*16 +: 16] = w;
            #1;
            checks++; if (ack !== 4'b0100 || data_1_en !== 1'b1 || data_1 !== w) begin errors++; $display("FAIL single_word%0d got ack=%h en=%b d=%h exp 4/1/%h", i, ack, data_1_en, data_1, w); end
            tick();
        end
        req = 4'h0;
        #1;
        checks++; if (ack !== 4'h0 || data_1_en !== 1'b0 || data_1 !== 16'h0) begin errors++; $display("FAIL single_drop got ack=%h en=%b d=%h exp 0/0/0", ack, data_1_en, data_1); end
        tick();
        checks++; if (grant !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL single_exit got g=%h b=%b exp 0/0", grant, busy); end
        // rr_ptr should now be 3: producer 3 beats producer 0
        req = 4'b1001;
        tick();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL single_rrptr got %h exp 8", grant); end
        req = 4'h0;
        tick();
        checks++; if (grant !== 4'h0) begin errors++; $display("FAIL single_rr_exit got %h exp 0", grant); end
    endtask

    task automatic test_burst_limit();
        // rr_ptr wrapped to 0
        req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL limit_grant got %h exp 1", grant); end
        for (int i = 0; i < 4; i++) begin
            req_data[0 +: 16] = 16'hD000 + 16'(i);
            #1;
            checks++; if (ack !== 4'b0001 || data_1 !== (16'hD000 + 16'(i))) begin errors++; $display("FAIL limit_word%0d got ack=%h d=%h exp 1/%h", i, ack, data_1, 16'hD000 + 16'(i)); end
            tick();
        end
        checks++; if (grant !== 4'h0 || busy !== 1'b0 || ack !== 4'h0) begin errors++; $display("FAIL limit_idle got g=%h b=%b a=%h exp 0/0/0", grant, busy, ack); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL limit_regrant got %h exp 1", grant); end
        req = 4'h0;
        tick();
        checks++; if (grant !== 4'h0) begin errors++; $display("FAIL limit_exit got %h exp 0", grant); end
    endtask

    task automatic test_fairness();
        logic [15:0] w;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req = 4'hF;
        #1;
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL fair_idle got %h exp 0", ack); end
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++; if (grant !== (4'b0001 << g)) begin errors++; $display("FAIL fair_grant%0d got %h exp %h", g, grant, 4'b0001 << g); end
            for (int i = 0; i < 4; i++) begin
                w = 16'h1000 * 16'(g + 1) + 16'(i);
                req_data[g*16 +: 16] = w;
                #1;
                checks++; if (ack !== (4'b0001 << g) || data_1 !== w) begin errors++; $display("FAIL fair_p%0d_w%0d got ack=%h d=%h exp %h/%h", g, i, ack, data_1, 4'b0001 << g, w); end
                tick();
            end
            checks++; if (grant !== 4'h0 || ack !== 4'h0) begin errors++; $display("FAIL fair_gap%0d got g=%h a=%h exp 0/0", g, grant, ack); end
        end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL fair_wrap got %h exp 1", grant); end
`ifdef FIFO_ARB_STATS_EN
        checks++; if (stats !== 64'h0004_0004_0004_0004) begin errors++; $display("FAIL fair_stats got %h exp 0004000400040004", stats); end
`endif
        req = 4'h0;
        tick();
        checks++; if (grant !== 4'h0) begin errors++; $display("FAIL fair_exit got %h exp 0", grant); end
    endtask

    task automatic test_full_stall();
        // rr_ptr is 1 after producer 0 left
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL stall_grant got %h exp 2", grant); end
        for (int i = 0; i < 2; i++) begin
            req_data[16 +: 16] = 16'hB001 + 16'(i);
            #1;
            checks++; if (ack !== 4'b0010 || data_1 !== (16'hB001 + 16'(i))) begin errors++; $display("FAIL stall_pre%0d got ack=%h d=%h exp 2/%h", i, ack, data_1, 16'hB001 + 16'(i)); end
            tick();
        end
        req_data[16 +: 16] = 16'hB003;
        buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ack !== 4'h0 || data_1_en !== 1'b0 || grant !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL stall_cyc%0d got a=%h en=%b g=%h b=%b exp 0/0/2/1", i, ack, data_1_en, grant, busy); end
            tick();
        end
        buffer_full = 1'b0;
        for (int i = 2; i < 4; i++) begin
            req_data[16 +: 16] = 16'hB001 + 16'(i);
            #1;
            checks++; if (ack !== 4'b0010 || data_1 !== (16'hB001 + 16'(i))) begin errors++; $display("FAIL stall_post%0d got ack=%h d=%h exp 2/%h", i, ack, data_1, 16'hB001 + 16'(i)); end
            tick();
        end
        checks++; if (grant !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL stall_exit got g=%h b=%b exp 0/0", grant, busy); end
        req = 4'h0;
    endtask

    task automatic test_async_reset();
        // rr_ptr is 2, so producer 3 is picked
        req = 4'b1000;
        tick();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL arst_grant got %h exp 8", grant); end
        req_data[48 +: 16] = 16'hC001;
        tick();
        req_data[48 +: 16] = 16'hC002;
        #1;
        checks++; if (ack !== 4'b1000 || data_1 !== 16'hC002) begin errors++; $display("FAIL arst_inflight got a=%h d=%h exp 8/c002", ack, data_1); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (grant !== 4'h0 || busy !== 1'b0 || ack !== 4'h0 || data_1_en !== 1'b0) begin errors++; $display("FAIL arst_immediate got g=%h b=%b a=%h en=%b exp 0", grant, busy, ack, data_1_en); end
        #1;
        reset = 1'b1;
        req = 4'b1010;
        #1;
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL arst_idle got %h exp 0", ack); end
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL arst_regrant got %h exp 2", grant); end
        req = 4'h0;
        tick();
    endtask

    task automatic test_drop_with_full();
        // rr_ptr is 2 after producer 1 left
        req = 4'b0100;
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL dropfull_grant got %h exp 4", grant); end
        req = 4'h0;
        buffer_full = 1'b1;
        #1;
        checks++; if (ack !== 4'h0 || data_1_en !== 1'b0) begin errors++; $display("FAIL dropfull_write got a=%h en=%b exp 0/0", ack, data_1_en); end
        tick();
        checks++; if (grant !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL dropfull_exit got g=%h b=%b exp 0/0", grant, busy); end
        buffer_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_limit();
        test_fairness();
        test_full_stall();
        test_async_reset();
        test_drop_with_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
